powlib_pipe: RTL

Parametrised D-stage register pipeline with valid tagging, bubble collapsing and optional ready backpressure. It generalises the single-register flip-flop primitive into a multi-stage, flow-controlled delay line. Datapath blocks use it for retiming and for absorbing downstream stalls without dropping words. It sits between any powlib valid/ready producer and consumer.

---
 rtl/powlib_pipe_pkg.sv | 15 +
 rtl/powlib_flipflop.sv | 34 +++
 rtl/powlib_pipe_stage.sv | 42 ++++
 rtl/powlib_pipe.sv | 78 +++++++
 4 files changed

// File: rtl/powlib_pipe_pkg.sv
// Shared helpers for the powlib pipeline slice.
// Provides the ceiling-log2 used to size the valid-stage counter.
package powlib_pipe_pkg;

  // Returns ceil(log2(v)); 0 for v <= 1.
  function automatic int unsigned powlib_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/powlib_flipflop.sv
// Single W-bit register with optional load enable and optional async reset.
// Reset value is INIT; EAR selects asynchronous reset when set.
module powlib_flipflop #(
  parameter int unsigned    W    = 1,
  parameter logic [W-1:0]   INIT = '0,
  parameter bit             EVLD = 1'b0,
  parameter bit             EAR  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic en;

  assign en = !EVLD || vld;

  generate
    if (EAR) begin : g_async
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= INIT;
        else if (en) q <= d;
      end
    end else begin : g_sync
      always_ff @(posedge clk) begin
        if (rst)     q <= INIT;
        else if (en) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/powlib_pipe_stage.sv
// One pipeline stage: data and valid registers sharing the advance enable.
// Data loads whenever the stage advances, independent of the incoming valid.
module powlib_pipe_stage #(
  parameter int unsigned  W    = 8,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         vin,
  input  logic         adv,
  output logic [W-1:0] dout,
  output logic         vout
);

  powlib_flipflop #(
    .W    (W),
    .INIT (INIT),
    .EVLD (1'b1),
    .EAR  (1'b0)
  ) u_data (
    .clk (clk),
    .rst (rst),
    .vld (adv),
    .d   (din),
    .q   (dout)
  );

  powlib_flipflop #(
    .W    (1),
    .INIT (1'b0),
    .EVLD (1'b1),
    .EAR  (1'b0)
  ) u_vld (
    .clk (clk),
    .rst (rst),
    .vld (adv),
    .d   (vin),
    .q   (vout)
  );

endmodule

// File: rtl/powlib_pipe.sv
// D-stage valid/ready register pipeline with bubble collapsing.
// The advance chain runs combinationally from the output stage back to irdy.
module powlib_pipe
  import powlib_pipe_pkg::*;
#(
  parameter int unsigned  W    = 8,
  parameter int unsigned  D    = 2,
  parameter logic [W-1:0] INIT = '0,
  parameter bit           EBP  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [W-1:0]                  d,
  input  logic                          ivld,
  output logic                          irdy,
  output logic [W-1:0]                  q,
  output logic                          ovld,
  input  logic                          ordy,
  output logic [powlib_clog2(D+1)-1:0]  cnt
);

  localparam int unsigned CW = powlib_clog2(D + 1);

  logic [W-1:0] data [D];
  logic [W-1:0] sdin [D];
  logic [D-1:0] vld;
  logic [D-1:0] svin;
  logic [D-1:0] adv;
  logic         ordy_eff;

  assign ordy_eff = ordy || !EBP;

  // A stage advances if it is empty or everything downstream advances.
  always_comb begin
    adv        = '0;
    adv[D-1]   = !vld[D-1] || ordy_eff;
    for (int unsigned k = 1; k < D; k++) begin
      adv[D-1-k] = !vld[D-1-k] || adv[D-k];
    end
  end

  generate
    for (genvar g = 0; g < D; g++) begin : g_stage
      if (g == 0) begin : g_head
        assign sdin[g] = d;
        assign svin[g] = ivld;
      end else begin : g_body
        assign sdin[g] = data[g-1];
        assign svin[g] = vld[g-1];
      end

      powlib_pipe_stage #(
        .W    (W),
        .INIT (INIT)
      ) u_stage (
        .clk  (clk),
        .rst  (rst),
        .din  (sdin[g]),
        .vin  (svin[g]),
        .adv  (adv[g]),
        .dout (data[g]),
        .vout (vld[g])
      );
    end
  endgenerate

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < D; i++) begin
      cnt = cnt + CW'(vld[i]);
    end
  end

  assign irdy = adv[0] || !EBP;
  assign q    = data[D-1];
  assign ovld = vld[D-1];

endmodule
